// File: rtl/lvg_seq_if.sv
// lvg_seq_if: sequencer <-> ROM / weight memory / lvg core signal bundle.
// master = sequencer side, slave = environment (ROM, memory, core, host).
interface lvg_seq_if #(
    parameter int IADDR_W = 8,
    parameter int MADDR_W = 8
);
    logic                 run;
    logic [IADDR_W-1:0]   imem_addr;
    logic [MADDR_W+7:0]   imem_data;
    logic                 mem_rd;
    logic                 mem_wr;
    logic [MADDR_W-1:0]   mem_addr;
    logic                 acc_load;
    logic [7:0]           core_op;
    logic                 core_start;
    logic                 core_done;
    logic                 busy;
    logic                 halted;
    logic                 err;

    modport master (
        input  run, imem_data, core_done,
        output imem_addr, mem_rd, mem_wr, mem_addr, acc_load,
        output core_op, core_start, busy, halted, err
    );

    modport slave (
        output run, imem_data, core_done,
        input  imem_addr, mem_rd, mem_wr, mem_addr, acc_load,
        input  core_op, core_start, busy, halted, err
    );
endinterface

// File: rtl/lvg_sequencer.sv
// lvg_sequencer: instruction sequencer for the lvg 4x4 systolic core.
// Ports: clk, rst (sync, active-high), bus (lvg_seq_if.master):
//   run in; imem_addr out / imem_data in (sync ROM, 1-cycle latency);
//   mem_rd/mem_wr/mem_addr, acc_load, core_op/core_start/core_done;
//   busy, halted, err status.
// Option: define LVG_SEQ_TIMEOUT_EN to bound WAIT to TIMEOUT cycles.
module lvg_sequencer #(
    parameter int IADDR_W = 8,
    parameter int MADDR_W = 8,
    parameter int TIMEOUT = 64
) (
    input logic        clk,
    input logic        rst,
    lvg_seq_if.master  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEMWAIT, S_WAIT, S_HALTED
    } state_t;

    localparam logic [7:0] OP_NOP     = 8'd0;
    localparam logic [7:0] OP_LOADACC = 8'd3;
    localparam logic [7:0] OP_STORE   = 8'd4;
    localparam logic [7:0] OP_LOOP    = 8'd9;
    localparam logic [7:0] OP_ENDLOOP = 8'd10;
    localparam logic [7:0] OP_HALT    = 8'hFF;

    state_t               state_q, state_d;
    logic [IADDR_W-1:0]   pc_q, pc_d, pc_inc;
    logic [7:0]           op_q, op_d;
    logic [MADDR_W-1:0]   maddr_q, maddr_d;
    logic [7:0]           cop_q, cop_d;
    logic [MADDR_W-1:0]   lcnt_q, lcnt_d;
    logic [IADDR_W-1:0]   lpc_q, lpc_d;
    logic                 err_q, err_d;
    logic                 rd, wr, acc, start;
    logic                 is_load, is_comp, dec_comp;
    logic [7:0]           dec_op;

`ifdef LVG_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]        to_q, to_d;
`else
    localparam int unused_timeout = TIMEOUT;
`endif

    assign pc_inc   = pc_q + 1'b1;
    assign is_load  = (op_q >= 8'd1) && (op_q <= 8'd3);
    assign is_comp  = (op_q >= 8'd5) && (op_q <= 8'd8);
    assign dec_op   = bus.imem_data[7:0];
    assign dec_comp = (dec_op >= 8'd5) && (dec_op <= 8'd8);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        op_d    = op_q;
        maddr_d = maddr_q;
        cop_d   = cop_q;
        lcnt_d  = lcnt_q;
        lpc_d   = lpc_q;
        err_d   = err_q;
        rd      = 1'b0;
        wr      = 1'b0;
        acc     = 1'b0;
        start   = 1'b0;
`ifdef LVG_SEQ_TIMEOUT_EN
        to_d    = to_q;
`endif
        unique case (state_q)
            S_IDLE, S_HALTED: begin
                if (bus.run) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    err_d   = 1'b0;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                op_d    = dec_op;
                maddr_d = bus.imem_data[MADDR_W+7:8];
                // Present the opcode together with core_start.
                if (dec_comp) cop_d = dec_op;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                unique case (1'b1)
                    (op_q == OP_NOP): begin
                        pc_d    = pc_inc;
                        state_d = S_FETCH;
                    end
                    is_load: begin
                        rd      = 1'b1;
                        state_d = S_MEMWAIT;
                    end
                    (op_q == OP_STORE): begin
                        wr      = 1'b1;
                        pc_d    = pc_inc;
                        state_d = S_FETCH;
                    end
                    is_comp: begin
                        start   = 1'b1;
                        state_d = S_WAIT;
`ifdef LVG_SEQ_TIMEOUT_EN
                        to_d    = '0;
`endif
                    end
                    (op_q == OP_LOOP): begin
                        lcnt_d  = maddr_q;
                        lpc_d   = pc_inc;
                        pc_d    = pc_inc;
                        state_d = S_FETCH;
                    end
                    (op_q == OP_ENDLOOP): begin
                        if (lcnt_q != '0) begin
                            lcnt_d = lcnt_q - 1'b1;
                            pc_d   = lpc_q;
                        end else begin
                            pc_d   = pc_inc;
                        end
                        state_d = S_FETCH;
                    end
                    (op_q == OP_HALT): state_d = S_HALTED;
                    default: begin
                        err_d   = 1'b1;
                        state_d = S_HALTED;
                    end
                endcase
            end
            S_MEMWAIT: begin
                acc     = (op_q == OP_LOADACC);
                pc_d    = pc_inc;
                state_d = S_FETCH;
            end
            S_WAIT: begin
                if (bus.core_done) begin
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end
`ifdef LVG_SEQ_TIMEOUT_EN
                else if (to_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_HALTED;
                end else begin
                    to_d    = to_q + 1'b1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            op_q    <= '0;
            maddr_q <= '0;
            cop_q   <= '0;
            lcnt_q  <= '0;
            lpc_q   <= '0;
            err_q   <= 1'b0;
`ifdef LVG_SEQ_TIMEOUT_EN
            to_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            op_q    <= op_d;
            maddr_q <= maddr_d;
            cop_q   <= cop_d;
            lcnt_q  <= lcnt_d;
            lpc_q   <= lpc_d;
            err_q   <= err_d;
`ifdef LVG_SEQ_TIMEOUT_EN
            to_q    <= to_d;
`endif
        end
    end

    // Strobes are decoded from state; masking with rst keeps an
    // aborted operation from emitting a pulse in the reset cycle.
    assign bus.mem_rd     = rd & ~rst;
    assign bus.mem_wr     = wr & ~rst;
    assign bus.acc_load   = acc & ~rst;
    assign bus.core_start = start & ~rst;
    assign bus.imem_addr  = pc_q;
    assign bus.mem_addr   = maddr_q;
    assign bus.core_op    = cop_q;
    assign bus.busy       = (state_q != S_IDLE) && (state_q != S_HALTED);
    assign bus.halted     = (state_q == S_HALTED);
    assign bus.err        = err_q;
endmodule

// File: tb/tb_lvg_sequencer.sv
// tb_lvg_sequencer: directed bench for lvg_sequencer with a sync ROM model.
// Define LVG_SEQ_TIMEOUT_EN to also exercise the WAIT timeout.
module tb_lvg_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lvg_seq_if #(.IADDR_W(8), .MADDR_W(8)) bus();

    lvg_sequencer #(.IADDR_W(8), .MADDR_W(8), .TIMEOUT(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [15:0] rom [256];
    always_ff @(posedge clk) bus.imem_data <= rom[bus.imem_addr];

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int wr_bad = 0;
    int rd_cnt = 0;
    int ovl    = 0;
    logic [7:0] wr_addr = '0;
    logic [7:0] rd_addr = '0;

    always @(negedge clk) begin
        if (bus.mem_wr) begin
            wr_cnt++;
            wr_addr = bus.mem_addr;
        end
        if (bus.mem_rd) begin
            rd_cnt++;
            rd_addr = bus.mem_addr;
        end
        if ((int'(bus.mem_rd) + int'(bus.mem_wr) + int'(bus.acc_load)
             + int'(bus.core_start)) > 1) ovl++;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'h00FF;
        wr_cnt = 0;
        wr_bad = 0;
        rd_cnt = 0;
    endtask

    task automatic run_prog();
        bus.run = 1'b1;
        step(1);
        bus.run = 1'b0;
    endtask

    task automatic wait_halt(input string tag, input int max);
        for (int i = 0; i < max && !bus.halted; i++) step(1);
        chk(tag, bus.halted, 1'b1);
    endtask

    initial begin
        bus.run       = 1'b0;
        bus.core_done = 1'b0;
        clear_rom();
        step(2);
        chk("rst_busy", bus.busy, 0);
        chk("rst_halted", bus.halted, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_iaddr", bus.imem_addr, 0);
        chk("rst_maddr", bus.mem_addr, 0);
        chk("rst_coreop", bus.core_op, 0);
        chk("rst_strobes", {bus.mem_rd, bus.mem_wr, bus.acc_load,
                            bus.core_start}, 0);
        rst = 1'b0;
        step(1);

        // LOAD 5; STORE 7; HALT : halted on the 11th edge counting run's
        clear_rom();
        rom[0] = 16'h0501;
        rom[1] = 16'h0704;
        run_prog();
        chk("t1_busy", bus.busy, 1);
        chk("t1_iaddr", bus.imem_addr, 0);
        step(2);
        chk("t1_rd", bus.mem_rd, 1);
        chk("t1_rd_addr", bus.mem_addr, 8'h05);
        step(7);
        chk("t1_not_halted", bus.halted, 0);
        step(1);
        chk("t1_halted", bus.halted, 1);
        chk("t1_err", bus.err, 0);
        chk("t1_rd_cnt", rd_cnt, 1);
        chk("t1_wr_cnt", wr_cnt, 1);
        chk("t1_wr_addr", wr_addr, 8'h07);

        // LOADACC 0x12: rd then acc_load on the next cycle, same addr
        clear_rom();
        rom[0] = 16'h1203;
        run_prog();
        step(2);
        chk("t2_rd", bus.mem_rd, 1);
        chk("t2_acc_early", bus.acc_load, 0);
        chk("t2_addr_n", bus.mem_addr, 8'h12);
        step(1);
        chk("t2_rd_off", bus.mem_rd, 0);
        chk("t2_acc", bus.acc_load, 1);
        chk("t2_addr_n1", bus.mem_addr, 8'h12);
        step(1);
        chk("t2_pc", bus.imem_addr, 1);
        wait_halt("t2_halt", 10);

        // compute op 6, core_done 10 cycles after core_start
        clear_rom();
        rom[0] = 16'h0006;
        run_prog();
        step(2);
        chk("t3_start", bus.core_start, 1);
        chk("t3_coreop", bus.core_op, 6);
        step(1);
        chk("t3_start_off", bus.core_start, 0);
        step(4);
        chk("t3_busy_wait", bus.busy, 1);
        step(5);
        bus.core_done = 1'b1;
        chk("t3_pc_hold", bus.imem_addr, 0);
        step(1);
        bus.core_done = 1'b0;
        chk("t3_pc_adv", bus.imem_addr, 1);
        chk("t3_busy", bus.busy, 1);
        step(3);
        chk("t3_halted", bus.halted, 1);
        chk("t3_coreop_hold", bus.core_op, 6);

        // LOOP 2; STORE 0x30; ENDLOOP; HALT
        clear_rom();
        rom[0] = 16'h0209;
        rom[1] = 16'h3004;
        rom[2] = 16'h000A;
        run_prog();
        wait_halt("t4_halt", 60);
        chk("t4_wr_cnt", wr_cnt, 3);
        chk("t4_wr_addr", wr_addr, 8'h30);
        chk("t4_loop_cnt", dut.lcnt_q, 0);
        chk("t4_err", bus.err, 0);

        // illegal opcode 0x42, then restart clears err
        clear_rom();
        rom[0] = 16'h0042;
        run_prog();
        wait_halt("t5_halt", 10);
        chk("t5_err", bus.err, 1);
        run_prog();
        chk("t5_err_clr", bus.err, 0);
        chk("t5_restart_pc", bus.imem_addr, 0);
        chk("t5_busy", bus.busy, 1);
        wait_halt("t5_halt2", 10);

        // reset while waiting on the core
        clear_rom();
        rom[0] = 16'h0907;
        run_prog();
        step(3);
        chk("t6_in_wait", bus.busy, 1);
        chk("t6_coreop", bus.core_op, 7);
        rst = 1'b1;
        step(1);
        chk("t6_busy", bus.busy, 0);
        chk("t6_halted", bus.halted, 0);
        chk("t6_err", bus.err, 0);
        chk("t6_coreop0", bus.core_op, 0);
        chk("t6_maddr", bus.mem_addr, 0);
        chk("t6_iaddr", bus.imem_addr, 0);
        chk("t6_strobes", {bus.mem_rd, bus.mem_wr, bus.acc_load,
                           bus.core_start}, 0);
        rst = 1'b0;
        step(1);

`ifdef LVG_SEQ_TIMEOUT_EN
        clear_rom();
        rom[0] = 16'h0005;
        run_prog();
        step(2);
        step(63);
        chk("t7_pre_to", bus.halted, 0);
        step(1);
        chk("t7_to_halt", bus.halted, 1);
        chk("t7_to_err", bus.err, 1);
        bus.core_done = 1'b1;
        step(1);
        bus.core_done = 1'b0;
        chk("t7_late_done", bus.halted, 1);
`endif

        chk("no_overlap", ovl, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
